// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings and inter-stage bundles for the 5-stage MIPS core.
// Conf (register control) and PCSource (next-PC select) codes live here.
package pipeline_pkg;

  localparam logic [1:0] CONF_LOAD  = 2'b00;
  localparam logic [1:0] CONF_HOLD  = 2'b01;
  localparam logic [1:0] CONF_FLUSH = 2'b10;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Conf-controlled pipeline register: load, hold, or flush (1x) a bundle.
// Flush wins over hold; the flush payload is supplied by the owning stage.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter type   data_t  = if_id_t,
  parameter data_t RST_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] conf,
  input  data_t      load_d,
  input  data_t      flush_d,
  output data_t      q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else begin
      unique case (1'b1)
        conf[1]:           q <= flush_d;
        conf == CONF_HOLD: q <= q;
        default:           q <= load_d;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC mux, and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic [1:0]  Conf1,
  input  logic [1:0]  PCSource1,
  input  logic [25:0] JumpTarget1,
  input  logic [31:0] JrTarget1,
  input  logic        IsBranch2,
  input  logic [31:0] BranchTarget2,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] Instr1,
  output logic [31:0] PC1,
  output logic        Valid1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] CntFetch,
  output logic [31:0] CntStall,
  output logic [31:0] CntFlush
`endif
);

  localparam if_id_t IFID_RST = '{
    instr: NOP_INSTR,
    pc:    32'h0,
    valid: 1'b0
  };

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        sel_br;
  logic        sel_hold;
  logic        sel_j;
  logic        sel_jr;
  if_id_t      load_d;
  if_id_t      flush_d;
  if_id_t      q;

  assign pc_plus4 = pc + 32'd4;
  assign ImemAddr = pc;

  // A taken branch overrides a stall: ID is being squashed anyway.
  assign sel_br   = IsBranch2;
  assign sel_hold = !IsBranch2 && !PCWrite;
  assign sel_j    = !IsBranch2 && PCWrite
                    && (PCSource1 == PCSRC_J);
  assign sel_jr   = !IsBranch2 && PCWrite
                    && (PCSource1 == PCSRC_JR);

  always_comb begin
    pc_next = pc_plus4;
    unique case (1'b1)
      sel_br:   pc_next = BranchTarget2;
      sel_hold: pc_next = pc;
      sel_j:    pc_next = {PC1[31:28],
                           JumpTarget1, 2'b00};
      sel_jr:   pc_next = JrTarget1;
      default:  pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC & ~32'h3;
    else       pc <= pc_next & ~32'h3;
  end

  assign load_d = '{
    instr: ImemData,
    pc:    pc_plus4,
    valid: 1'b1
  };

  assign flush_d = '{
    instr: NOP_INSTR,
    pc:    pc_plus4,
    valid: 1'b0
  };

  if_id_reg #(
    .data_t  (if_id_t),
    .RST_VAL (IFID_RST)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .conf    (Conf1),
    .load_d  (load_d),
    .flush_d (flush_d),
    .q       (q)
  );

  assign Instr1 = q.instr;
  assign PC1    = q.pc;
  assign Valid1 = q.valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      CntFetch <= '0;
      CntStall <= '0;
      CntFlush <= '0;
    end else begin
      if (Conf1 == CONF_LOAD && CntFetch != '1)
        CntFetch <= CntFetch + 32'd1;
      if (sel_hold && CntStall != '1)
        CntStall <= CntStall + 32'd1;
      if (Conf1[1] && CntFlush != '1)
        CntFlush <= CntFlush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem model returns ~address.
// Build with +define+FETCH_PERF_CNT_EN to also check the counters.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic [1:0]  Conf1;
  logic [1:0]  PCSource1;
  logic [25:0] JumpTarget1;
  logic [31:0] JrTarget1;
  logic        IsBranch2;
  logic [31:0] BranchTarget2;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic [31:0] Instr1;
  logic [31:0] PC1;
  logic        Valid1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] CntFetch;
  logic [31:0] CntStall;
  logic [31:0] CntFlush;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign ImemData = ~ImemAddr;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PCWrite       (PCWrite),
    .Conf1         (Conf1),
    .PCSource1     (PCSource1),
    .JumpTarget1   (JumpTarget1),
    .JrTarget1     (JrTarget1),
    .IsBranch2     (IsBranch2),
    .BranchTarget2 (BranchTarget2),
    .ImemAddr      (ImemAddr),
    .ImemData      (ImemData),
    .Instr1        (Instr1),
    .PC1           (PC1),
    .Valid1        (Valid1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .CntFetch      (CntFetch),
    .CntStall      (CntStall),
    .CntFlush      (CntFlush)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCWrite       = 1'b1;
    Conf1         = 2'b00;
    PCSource1     = 2'b00;
    JumpTarget1   = '0;
    JrTarget1     = '0;
    IsBranch2     = 1'b0;
    BranchTarget2 = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (ImemAddr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_addr: got %h want %h", ImemAddr, 32'h0);
    end
    vectors++;
    if (Instr1 !== 32'h0 || PC1 !== 32'h0 || Valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ifid: got %h/%h/%b want 0/0/0", Instr1, PC1, Valid1);
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if (CntFetch !== 0 || CntStall !== 0 || CntFlush !== 0) begin
      miscompares++;
      $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", CntFetch, CntStall, CntFlush);
    end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a = 32'(4 * i);
      tick();
      vectors++;
      if (ImemAddr !== a || PC1 !== a || Instr1 !== ~(a - 32'd4) || Valid1 !== 1'b1) begin
        miscompares++;
        $display("FAIL seq%0d: got %h/%h/%h/%b want %h/%h/%h/1",
                 i, ImemAddr, PC1, Instr1, Valid1, a, a, ~(a - 32'd4));
      end
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if (CntFetch !== 32'd3) begin
      miscompares++;
      $display("FAIL cnt_fetch: got %0d want 3", CntFetch);
    end
`endif
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (ImemAddr !== 32'h20) begin
      miscompares++;
      $display("FAIL stall_pre: got %h want %h", ImemAddr, 32'h20);
    end
    PCWrite = 1'b0;
    Conf1   = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (ImemAddr !== 32'h20 || PC1 !== 32'h20 || Instr1 !== ~32'h1C || Valid1 !== 1'b1) begin
        miscompares++;
        $display("FAIL stall%0d: got %h/%h/%h/%b want 20/20/%h/1",
                 i, ImemAddr, PC1, Instr1, Valid1, ~32'h1C);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if (CntStall !== 32'd2) begin
      miscompares++;
      $display("FAIL cnt_stall: got %0d want 2", CntStall);
    end
`endif
    idle();
    tick();
    vectors++;
    if (ImemAddr !== 32'h24 || PC1 !== 32'h24 || Instr1 !== ~32'h20) begin
      miscompares++;
      $display("FAIL stall_rel: got %h/%h/%h want 24/24/%h", ImemAddr, PC1, Instr1, ~32'h20);
    end
  endtask

  task automatic test_jump();
    IsBranch2     = 1'b1;
    BranchTarget2 = 32'h0040_000C;
    tick();
    idle();
    tick();
    vectors++;
    if (ImemAddr !== 32'h0040_0010 || PC1 !== 32'h0040_0010) begin
      miscompares++;
      $display("FAIL j_setup: got %h/%h want 00400010/00400010", ImemAddr, PC1);
    end
    PCSource1   = 2'b01;
    JumpTarget1 = 26'h010_0040;
    tick();
    vectors++;
    if (ImemAddr !== 32'h0040_0100) begin
      miscompares++;
      $display("FAIL j_addr: got %h want %h", ImemAddr, 32'h0040_0100);
    end
    vectors++;
    if (Instr1 !== ~32'h0040_0010 || PC1 !== 32'h0040_0014 || Valid1 !== 1'b1) begin
      miscompares++;
      $display("FAIL j_slot: got %h/%h/%b want %h/00400014/1",
               Instr1, PC1, Valid1, ~32'h0040_0010);
    end
    idle();
  endtask

  task automatic test_branch_over_stall();
    IsBranch2     = 1'b1;
    BranchTarget2 = 32'h80;
    PCWrite       = 1'b0;
    Conf1         = 2'b10;
    tick();
    vectors++;
    if (ImemAddr !== 32'h80) begin
      miscompares++;
      $display("FAIL br_addr: got %h want %h", ImemAddr, 32'h80);
    end
    vectors++;
    if (Instr1 !== 32'h0 || Valid1 !== 1'b0 || PC1 !== 32'h0040_0104) begin
      miscompares++;
      $display("FAIL br_flush: got %h/%b/%h want 0/0/00400104", Instr1, Valid1, PC1);
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if (CntFlush !== 32'd1 || CntStall !== 32'd2) begin
      miscompares++;
      $display("FAIL cnt_br: got %0d/%0d want 1/2", CntFlush, CntStall);
    end
`endif
    idle();
  endtask

  task automatic test_jr_wrap();
    PCSource1 = 2'b10;
    JrTarget1 = 32'h1003;
    tick();
    vectors++;
    if (ImemAddr !== 32'h1000 || PC1 !== 32'h84 || Instr1 !== ~32'h80 || Valid1 !== 1'b1) begin
      miscompares++;
      $display("FAIL jr: got %h/%h/%h/%b want 1000/84/%h/1", ImemAddr, PC1, Instr1, Valid1, ~32'h80);
    end
    idle();
    IsBranch2     = 1'b1;
    BranchTarget2 = 32'hFFFF_FFFE;
    tick();
    vectors++;
    if (ImemAddr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL br_align: got %h want %h", ImemAddr, 32'hFFFF_FFFC);
    end
    idle();
    tick();
    vectors++;
    if (ImemAddr !== 32'h0 || PC1 !== 32'h0 || Instr1 !== 32'h3) begin
      miscompares++;
      $display("FAIL wrap: got %h/%h/%h want 0/0/3", ImemAddr, PC1, Instr1);
    end
  endtask

  task automatic test_conf11();
    Conf1 = 2'b11;
    tick();
    vectors++;
    if (Instr1 !== 32'h0 || Valid1 !== 1'b0 || PC1 !== 32'h4 || ImemAddr !== 32'h4) begin
      miscompares++;
      $display("FAIL conf11: got %h/%b/%h/%h want 0/0/4/4", Instr1, Valid1, PC1, ImemAddr);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_in_hold();
    PCWrite = 1'b0;
    Conf1   = 2'b01;
    tick();
    vectors++;
    if (Valid1 !== 1'b1 || ImemAddr !== 32'h8) begin
      miscompares++;
      $display("FAIL hold_pre: got %b/%h want 1/8", Valid1, ImemAddr);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (ImemAddr !== 32'h0 || Valid1 !== 1'b0 || Instr1 !== 32'h0 || PC1 !== 32'h0) begin
      miscompares++;
      $display("FAIL hold_rst: got %h/%b/%h/%h want 0/0/0/0", ImemAddr, Valid1, Instr1, PC1);
    end
`ifdef FETCH_PERF_CNT_EN
    vectors++;
    if (CntFetch !== 0 || CntStall !== 0 || CntFlush !== 0) begin
      miscompares++;
      $display("FAIL hold_cnt: got %0d/%0d/%0d want 0/0/0", CntFetch, CntStall, CntFlush);
    end
`endif
    reset = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch_over_stall();
    test_jr_wrap();
    test_conf11();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
